// File: rtl/iir_coef_pkg.sv
// Shared constants, types and default coefficient table for the IIR biquad coefficient sequencer.
package iir_coef_pkg;

  localparam int unsigned WIDTH     = 22;
  localparam int unsigned FRAC      = 14;
  localparam int unsigned NUM_COEF  = 5;
  localparam int unsigned NUM_BANDS = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic [IDX_W-1:0] {B0, B1, B2, A1, A2} coef_idx_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_STREAM = 1'b1;

  // Rows: mute, bajo, medio, alto; columns in b0, b1, b2, a1, a2 order (Q7.14)
  localparam logic [WIDTH-1:0] DEFAULT_TABLE [NUM_BANDS][NUM_COEF] = '{
    '{22'h000000, 22'h000000, 22'h000000, 22'h000000, 22'h000000},
    '{22'h004000, 22'h3F8042, 22'h004000, 22'h3F8100, 22'h003F00},
    '{22'h003E00, 22'h3F8000, 22'h003E00, 22'h3F8400, 22'h003C00},
    '{22'h003A00, 22'h3FB323, 22'h003A00, 22'h3FB800, 22'h003400}
  };

  // Unknown bands fall back to mute.
  function automatic logic [SEL_W-1:0] band_map(input logic [SEL_W-1:0] s);
    return (32'(s) < NUM_BANDS) ? s : '0;
  endfunction

endpackage

// File: rtl/iir_coef_sequencer_if.sv
// Coefficient stream from the sequencer (master) to the time-multiplexed MAC (slave).
interface iir_coef_sequencer_if;
  import iir_coef_pkg::*;

  logic             coef_valid;
  logic             coef_ready;
  logic [IDX_W-1:0] coef_idx;
  logic [WIDTH-1:0] coef_data;

  modport master (output coef_valid, output coef_idx, output coef_data, input coef_ready);
  modport slave  (input coef_valid, input coef_idx, input coef_data, output coef_ready);
endinterface

// File: rtl/iir_coef_table.sv
// Coefficient bank with a registered read port; IIR_COEF_LOAD_EN makes it a writable RAM reset to the defaults.
module iir_coef_table
  import iir_coef_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
`ifdef IIR_COEF_LOAD_EN
  input  logic             i_wr_en,
  input  logic [SEL_W-1:0] i_wr_band,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [WIDTH-1:0] i_wr_data,
`endif
  input  logic [SEL_W-1:0] i_rd_band,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_rd_data;

`ifdef IIR_COEF_LOAD_EN
  logic [WIDTH-1:0] r_mem [NUM_BANDS][NUM_COEF];
  logic             w_wr_ok;
  logic             w_bypass;

  assign w_wr_ok  = i_wr_en && (32'(i_wr_band) < NUM_BANDS) && (32'(i_wr_idx) < NUM_COEF);
  // Same-edge write to the location being read is forwarded so the read never returns stale data.
  assign w_bypass = w_wr_ok && (i_wr_band == i_rd_band) && (i_wr_idx == i_rd_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem <= DEFAULT_TABLE;
    end else if (w_wr_ok) begin
      r_mem[i_wr_band][i_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_bypass ? i_wr_data : r_mem[i_rd_band][i_rd_idx];
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= DEFAULT_TABLE[i_rd_band][i_rd_idx];
    end
  end
`endif

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/iir_coef_sequencer.sv
// Streams the active band's biquad coefficients to the MAC once per sample tick.
// Optional runtime coefficient loading is enabled with IIR_COEF_LOAD_EN.
module iir_coef_sequencer
  import iir_coef_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sample_tick,
  iir_coef_sequencer_if.master  coef_if,
`ifdef IIR_COEF_LOAD_EN
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_band,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_ready,
`endif
  output logic                  stream_done,
  output logic [SEL_W-1:0]      band_active,
  output logic                  overrun
);

  state_t           r_state,   w_state_nxt;
  logic [SEL_W-1:0] r_band,    w_band_nxt;
  logic [IDX_W-1:0] r_idx,     w_idx_nxt;
  logic             r_valid,   w_valid_nxt;
  logic             r_done,    w_done_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic [SEL_W-1:0] r_pending;
  logic [WIDTH-1:0] w_rd_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= band_map(sel);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_band    <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_band    <= w_band_nxt;
      r_idx     <= w_idx_nxt;
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Ticks are only honoured in IDLE; in STREAM (including the last accept) they are dropped as overruns.
  always_comb begin
    w_state_nxt   = r_state;
    w_band_nxt    = r_band;
    w_idx_nxt     = r_idx;
    w_valid_nxt   = r_valid;
    w_done_nxt    = 1'b0;
    w_overrun_nxt = r_overrun;
    case (r_state)
      ST_IDLE: begin
        if (sample_tick) begin
          w_state_nxt = ST_STREAM;
          w_band_nxt  = r_pending;
          w_idx_nxt   = IDX_W'(B0);
          w_valid_nxt = 1'b1;
        end
      end
      ST_STREAM: begin
        if (sample_tick) begin
          w_overrun_nxt = 1'b1;
        end
        if (r_valid && coef_if.coef_ready) begin
          if (r_idx == IDX_W'(A2)) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

`ifdef IIR_COEF_LOAD_EN
  assign wr_ready = !((r_state == ST_STREAM) && (wr_band == r_band));
`endif

  // Read address follows the next-state band/index so data lines up with coef_valid/coef_idx.
  iir_coef_table u_table (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef IIR_COEF_LOAD_EN
    .i_wr_en   (wr_en && wr_ready),
    .i_wr_band (wr_band),
    .i_wr_idx  (wr_idx),
    .i_wr_data (wr_data),
`endif
    .i_rd_band (w_band_nxt),
    .i_rd_idx  (w_idx_nxt),
    .o_rd_data (w_rd_data)
  );

  assign coef_if.coef_valid = r_valid;
  assign coef_if.coef_idx   = r_idx;
  assign coef_if.coef_data  = w_rd_data;
  assign stream_done        = r_done;
  assign band_active        = r_band;
  assign overrun            = r_overrun;

endmodule
